// File: rtl/stage_if_prefetch_if.sv
//==============================================================================
// stage_if_prefetch_if : fetch-stage bundle (instruction memory + decode side)
// Revision: 1.0
//==============================================================================
`default_nettype none

interface stage_if_prefetch_if #(
   parameter int DEPTH = 4
);
   localparam int c_OCC_W = $clog2(DEPTH + 1);

   logic [31:0]        PC;
   logic               Inst_Req_Valid;
   logic               Inst_Req_Ready;
   logic [31:0]        Instruction;
   logic               Inst_Valid;
   logic               Inst_Ready;
   logic [31:0]        IR;
   logic [31:0]        PC_O;
   logic               Done_O;
   logic               Stall_I;
   logic               Feedback_Branch;
   logic [31:0]        next_PC;
   logic [c_OCC_W-1:0] Occupancy;

   // master = fetch stage, slave = memory / decode / EX environment
   modport master (
      output PC, Inst_Req_Valid, Inst_Ready, IR, PC_O, Done_O, Occupancy,
      input  Inst_Req_Ready, Instruction, Inst_Valid, Stall_I, Feedback_Branch, next_PC
   );

   modport slave (
      input  PC, Inst_Req_Valid, Inst_Ready, IR, PC_O, Done_O, Occupancy,
      output Inst_Req_Ready, Instruction, Inst_Valid, Stall_I, Feedback_Branch, next_PC
   );
endinterface

`default_nettype wire

// File: rtl/stage_if_prefetch.sv
//==============================================================================
// stage_if_prefetch : instruction fetch with DEPTH-entry {PC, instr} prefetch queue
// Revision: 1.0
//==============================================================================
`default_nettype none

module stage_if_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic           clk,
   input  wire logic           rst,
   stage_if_prefetch_if.master bus
);
   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_OCC_W = $clog2(DEPTH + 1);
   localparam logic [c_OCC_W-1:0] c_FULL  = c_OCC_W'(DEPTH);

   typedef enum logic [1:0] {
      s_INIT = 2'd0,
      s_REQ  = 2'd1,
      s_WAIT = 2'd2,
      s_DROP = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_inst_ready;
   logic [31:0]         r_pc;
   logic [31:0]         r_req_pc;
   logic [c_PTR_W-1:0]  r_wptr;
   logic [c_PTR_W-1:0]  r_rptr;
   logic [c_OCC_W-1:0]  r_occ;
   logic [31:0]         r_mem_pc [DEPTH];
   logic [31:0]         r_mem_ir [DEPTH];

   logic w_req_valid;
   logic w_issue;
   logic w_flush;
   logic w_push;
   logic w_pop;
   logic w_done;

   assign w_flush     = bus.Feedback_Branch;
   assign w_done      = (r_occ != '0);
   assign w_req_valid = (r_state == s_REQ) && (r_occ < c_FULL);
   assign w_issue     = w_req_valid && bus.Inst_Req_Ready;
   assign w_push      = (r_state == s_WAIT) && bus.Inst_Valid && !w_flush;
   assign w_pop       = w_done && !bus.Stall_I && !w_flush;

   // One request outstanding at most; a redirect while waiting turns the
   // pending response into one that must be swallowed (s_DROP).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= s_INIT;
         r_inst_ready <= 1'b1;
         r_pc         <= RESET_PC;
         r_req_pc     <= RESET_PC;
      end else begin
         case (r_state)
            s_INIT: begin
               r_state      <= s_REQ;
               r_inst_ready <= 1'b0;
               if (w_flush) r_pc <= bus.next_PC;
            end
            s_REQ: begin
               if (w_issue) begin
                  r_inst_ready <= 1'b1;
                  if (w_flush) begin
                     r_state <= s_DROP;
                     r_pc    <= bus.next_PC;
                  end else begin
                     r_state  <= s_WAIT;
                     r_pc     <= r_pc + 32'd4;
                     r_req_pc <= r_pc;
                  end
               end else if (w_flush) begin
                  r_pc <= bus.next_PC;
               end
            end
            s_WAIT: begin
               if (bus.Inst_Valid) begin
                  r_state      <= s_REQ;
                  r_inst_ready <= 1'b0;
                  if (w_flush) r_pc <= bus.next_PC;
               end else if (w_flush) begin
                  r_state <= s_DROP;
                  r_pc    <= bus.next_PC;
               end
            end
            s_DROP: begin
               if (w_flush) r_pc <= bus.next_PC;
               if (bus.Inst_Valid) begin
                  r_state      <= s_REQ;
                  r_inst_ready <= 1'b0;
               end
            end
            default: begin
               r_state      <= s_INIT;
               r_inst_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else if (w_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
         if (w_push && !w_pop)
            r_occ <= r_occ + c_OCC_W'(1);
         else if (!w_push && w_pop)
            r_occ <= r_occ - c_OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wptr] <= r_req_pc;
         r_mem_ir[r_wptr] <= bus.Instruction;
      end
   end

   assign bus.PC             = r_pc;
   assign bus.Inst_Req_Valid = w_req_valid;
   assign bus.Inst_Ready     = r_inst_ready;
   assign bus.IR             = r_mem_ir[r_rptr];
   assign bus.PC_O           = r_mem_pc[r_rptr];
   assign bus.Done_O         = w_done;
   assign bus.Occupancy      = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_stage_if_prefetch.sv
//==============================================================================
// tb_stage_if_prefetch : directed bench with latency-programmable memory model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_stage_if_prefetch;
   logic clk = 1'b0;
   logic rst = 1'b1;

   stage_if_prefetch_if #(.DEPTH(4)) bus ();

   stage_if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          lat = 1;
   int          cnt = 0;
   int          max_occ = 0;
   logic        pend = 1'b0;
   logic        auto_mem = 1'b1;
   logic [31:0] paddr = '0;
   logic [31:0] issued [$];
   logic [31:0] pop_pc [$];
   logic [31:0] pop_ir [$];

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // One clock: record handshakes/pops seen before the edge, then update the memory model
   task automatic step();
      logic        hs, taken, popv;
      logic [31:0] a;
      hs    = !rst && bus.Inst_Req_Valid && bus.Inst_Req_Ready;
      a     = bus.PC;
      taken = bus.Inst_Valid && bus.Inst_Ready;
      popv  = !rst && bus.Done_O && !bus.Stall_I && !bus.Feedback_Branch;
      if (popv) begin
         pop_pc.push_back(bus.PC_O);
         pop_ir.push_back(bus.IR);
      end
      if (hs) issued.push_back(a);
      @(posedge clk);
      #1;
      if (int'(bus.Occupancy) > max_occ) max_occ = int'(bus.Occupancy);
      if (rst) pend = 1'b0;
      else begin
         if (taken) pend = 1'b0;
         if (hs) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = a;
         end
      end
      if (auto_mem) begin
         bus.Inst_Valid  = pend && (cnt == 1);
         bus.Instruction = bus.Inst_Valid ? memword(paddr) : 32'h0;
         if (pend && cnt > 1) cnt--;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      auto_mem = 1'b1;
      pend = 1'b0;
      bus.Inst_Valid = 1'b0;
      bus.Instruction = '0;
      bus.Feedback_Branch = 1'b0;
      bus.next_PC = '0;
      bus.Inst_Req_Ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      issued.delete();
      pop_pc.delete();
      pop_ir.delete();
      max_occ = 0;
   endtask

   task automatic test_reset();
      bus.Stall_I = 1'b0;
      bus.Inst_Valid = 1'b0;
      bus.Instruction = '0;
      bus.Feedback_Branch = 1'b0;
      bus.next_PC = '0;
      bus.Inst_Req_Ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      n_vec++; if (bus.Occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d exp 0", bus.Occupancy); end
      n_vec++; if (bus.Done_O !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.Done_O); end
      n_vec++; if (bus.Inst_Req_Valid !== 1'b0) begin n_err++; $display("FAIL reset_reqv got %b exp 0", bus.Inst_Req_Valid); end
      n_vec++; if (bus.PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", bus.PC); end
      n_vec++; if (bus.Inst_Ready !== 1'b1) begin n_err++; $display("FAIL reset_iready got %b exp 1", bus.Inst_Ready); end
      rst = 1'b0;
      step();
      n_vec++; if (bus.Inst_Req_Valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid got %b exp 1", bus.Inst_Req_Valid); end
      n_vec++; if (bus.PC !== 32'h0) begin n_err++; $display("FAIL first_req_pc got %h exp 0", bus.PC); end
   endtask

   task automatic test_linear();
      bus.Stall_I = 1'b0;
      lat = 1;
      do_reset();
      for (int k = 0; k < 60 && pop_pc.size() < 5; k++) step();
      n_vec++; if (pop_pc.size() < 5) begin n_err++; $display("FAIL linear_pops got %0d exp 5", pop_pc.size()); end
      for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
         n_vec++; if (pop_pc[i] !== 32'(4 * i)) begin n_err++; $display("FAIL linear_pc[%0d] got %h exp %h", i, pop_pc[i], 4 * i); end
         n_vec++; if (pop_ir[i] !== memword(32'(4 * i))) begin n_err++; $display("FAIL linear_ir[%0d] got %h exp %h", i, pop_ir[i], memword(32'(4 * i))); end
      end
      n_vec++; if (max_occ > 1) begin n_err++; $display("FAIL linear_max_occ got %0d exp <=1", max_occ); end
   endtask

   task automatic test_backpressure();
      bus.Stall_I = 1'b1;
      lat = 1;
      do_reset();
      for (int k = 0; k < 30; k++) step();
      n_vec++; if (issued.size() != 4) begin n_err++; $display("FAIL bp_req_count got %0d exp 4", issued.size()); end
      for (int i = 0; i < 4 && i < issued.size(); i++) begin
         n_vec++; if (issued[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_req_pc[%0d] got %h exp %h", i, issued[i], 4 * i); end
      end
      n_vec++; if (bus.Occupancy !== 3'd4) begin n_err++; $display("FAIL bp_occ got %0d exp 4", bus.Occupancy); end
      n_vec++; if (bus.Inst_Req_Valid !== 1'b0) begin n_err++; $display("FAIL bp_reqv got %b exp 0", bus.Inst_Req_Valid); end
      n_vec++; if (bus.Done_O !== 1'b1) begin n_err++; $display("FAIL bp_done got %b exp 1", bus.Done_O); end
      n_vec++; if (bus.PC_O !== 32'h0) begin n_err++; $display("FAIL bp_head_pc got %h exp 0", bus.PC_O); end
      n_vec++; if (bus.IR !== memword(32'h0)) begin n_err++; $display("FAIL bp_head_ir got %h exp %h", bus.IR, memword(32'h0)); end
      bus.Stall_I = 1'b0;
      for (int k = 0; k < 60 && pop_pc.size() < 5; k++) step();
      n_vec++; if (pop_pc.size() < 5) begin n_err++; $display("FAIL bp_pops got %0d exp 5", pop_pc.size()); end
      for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
         n_vec++; if (pop_pc[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_pop_pc[%0d] got %h exp %h", i, pop_pc[i], 4 * i); end
      end
      n_vec++; if (issued.size() < 5 || issued[4] !== 32'h10) begin n_err++; $display("FAIL bp_resume got %0d reqs exp 5th at 00000010", issued.size()); end
   endtask

   task automatic test_branch_wait();
      bus.Stall_I = 1'b0;
      lat = 4;
      do_reset();
      for (int k = 0; k < 80 && issued.size() < 5; k++) step();
      n_vec++; if (issued.size() != 5 || issued[4] !== 32'h10) begin n_err++; $display("FAIL bw_setup got %0d reqs exp 5 ending at 00000010", issued.size()); end
      bus.Feedback_Branch = 1'b1;
      bus.next_PC = 32'h100;
      step();
      bus.Feedback_Branch = 1'b0;
      n_vec++; if (bus.Occupancy !== 3'd0) begin n_err++; $display("FAIL bw_occ got %0d exp 0", bus.Occupancy); end
      n_vec++; if (bus.Done_O !== 1'b0) begin n_err++; $display("FAIL bw_done got %b exp 0", bus.Done_O); end
      n_vec++; if (bus.PC !== 32'h100) begin n_err++; $display("FAIL bw_pc got %h exp 00000100", bus.PC); end
      n_vec++; if (bus.Inst_Req_Valid !== 1'b0) begin n_err++; $display("FAIL bw_drop_reqv got %b exp 0", bus.Inst_Req_Valid); end
      issued.delete();
      pop_pc.delete();
      pop_ir.delete();
      for (int k = 0; k < 60 && pop_pc.size() < 2; k++) step();
      n_vec++; if (issued.size() < 1 || issued[0] !== 32'h100) begin n_err++; $display("FAIL bw_next_req got %0d reqs exp first 00000100", issued.size()); end
      n_vec++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104) begin n_err++; $display("FAIL bw_pop_pc got %0d pops exp 00000100,00000104", pop_pc.size()); end
      n_vec++; if (pop_ir.size() < 1 || pop_ir[0] !== memword(32'h100)) begin n_err++; $display("FAIL bw_pop_ir got %0d pops exp ir %h", pop_ir.size(), memword(32'h100)); end
   endtask

   task automatic test_branch_coincident();
      bus.Stall_I = 1'b1;
      lat = 1;
      do_reset();
      for (int k = 0; k < 20 && issued.size() < 2; k++) step();
      n_vec++; if (bus.Done_O !== 1'b1 || bus.Inst_Ready !== 1'b1) begin n_err++; $display("FAIL bc_setup got done=%b iready=%b exp 1,1", bus.Done_O, bus.Inst_Ready); end
      bus.Stall_I = 1'b0;
      bus.Feedback_Branch = 1'b1;
      bus.next_PC = 32'h40;
      issued.delete();
      pop_pc.delete();
      pop_ir.delete();
      step();
      bus.Feedback_Branch = 1'b0;
      n_vec++; if (bus.Occupancy !== 3'd0) begin n_err++; $display("FAIL bc_occ got %0d exp 0", bus.Occupancy); end
      n_vec++; if (bus.Done_O !== 1'b0) begin n_err++; $display("FAIL bc_done got %b exp 0", bus.Done_O); end
      n_vec++; if (bus.PC !== 32'h40 || bus.Inst_Req_Valid !== 1'b1) begin n_err++; $display("FAIL bc_req got pc=%h v=%b exp 00000040,1", bus.PC, bus.Inst_Req_Valid); end
      for (int k = 0; k < 30 && pop_pc.size() < 1; k++) step();
      n_vec++; if (issued.size() < 1 || issued[0] !== 32'h40) begin n_err++; $display("FAIL bc_issue got %0d reqs exp first 00000040", issued.size()); end
      n_vec++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h40) begin n_err++; $display("FAIL bc_pop got %0d pops exp first 00000040", pop_pc.size()); end
   endtask

   task automatic test_push_pop_wrap();
      bus.Stall_I = 1'b1;
      lat = 1;
      do_reset();
      for (int k = 0; k < 30 && issued.size() < 3; k++) step();
      n_vec++; if (bus.Occupancy !== 3'd2) begin n_err++; $display("FAIL pp_setup_occ got %0d exp 2", bus.Occupancy); end
      bus.Stall_I = 1'b0;
      step();
      n_vec++; if (bus.Occupancy !== 3'd2) begin n_err++; $display("FAIL pp_occ got %0d exp 2", bus.Occupancy); end
      n_vec++; if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin n_err++; $display("FAIL pp_pop got %0d pops exp one at 00000000", pop_pc.size()); end
      for (int k = 0; k < 100 && pop_pc.size() < 7; k++) step();
      n_vec++; if (pop_pc.size() < 7) begin n_err++; $display("FAIL wrap_pops got %0d exp 7", pop_pc.size()); end
      for (int i = 0; i < 7 && i < pop_pc.size(); i++) begin
         n_vec++; if (pop_pc[i] !== 32'(4 * i) || pop_ir[i] !== memword(32'(4 * i))) begin n_err++; $display("FAIL wrap[%0d] got pc=%h ir=%h exp pc=%h", i, pop_pc[i], pop_ir[i], 4 * i); end
      end
   endtask

   task automatic test_reset_in_drop();
      bus.Stall_I = 1'b0;
      lat = 3;
      do_reset();
      for (int k = 0; k < 20 && issued.size() < 1; k++) step();
      bus.Feedback_Branch = 1'b1;
      bus.next_PC = 32'h200;
      step();
      bus.Feedback_Branch = 1'b0;
      n_vec++; if (bus.PC !== 32'h200 || bus.Inst_Req_Valid !== 1'b0) begin n_err++; $display("FAIL rd_drop got pc=%h v=%b exp 00000200,0", bus.PC, bus.Inst_Req_Valid); end
      #3 rst = 1'b1;
      #1;
      n_vec++; if (bus.PC !== 32'h0) begin n_err++; $display("FAIL rd_async_pc got %h exp 0", bus.PC); end
      n_vec++; if (bus.Inst_Ready !== 1'b1 || bus.Inst_Req_Valid !== 1'b0 || bus.Done_O !== 1'b0) begin n_err++; $display("FAIL rd_async_out got ir=%b v=%b d=%b exp 1,0,0", bus.Inst_Ready, bus.Inst_Req_Valid, bus.Done_O); end
      step();
      rst = 1'b0;
      auto_mem = 1'b0;
      bus.Inst_Valid = 1'b1;
      bus.Instruction = 32'hBAD0_BAD0;
      issued.delete();
      pop_pc.delete();
      pop_ir.delete();
      step();
      bus.Inst_Valid = 1'b0;
      bus.Instruction = '0;
      auto_mem = 1'b1;
      n_vec++; if (bus.Occupancy !== 3'd0) begin n_err++; $display("FAIL rd_stale_occ got %0d exp 0", bus.Occupancy); end
      for (int k = 0; k < 30 && pop_pc.size() < 1; k++) step();
      n_vec++; if (issued.size() < 1 || issued[0] !== 32'h0) begin n_err++; $display("FAIL rd_first_req got %0d reqs exp first 00000000", issued.size()); end
      n_vec++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_ir[0] !== memword(32'h0)) begin n_err++; $display("FAIL rd_first_pop got %0d pops exp pc 0 ir %h", pop_pc.size(), memword(32'h0)); end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_backpressure();
      test_branch_wait();
      test_branch_coincident();
      test_push_pop_wrap();
      test_reset_in_drop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", n_vec);
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
